fourstate_word_rx: RTL and testbench
====================================

FOURSTATE_WORD_RX -- requirements
Module: fourstate_word_rx

Interface
REQ-001 SHALL have parameter WORD_BITS, default 12, giving the width of the reassembled 4-state word (legal range 2..64).
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset; synchronous and active-low.
REQ-004 SHALL have port sym_valid, input, 1, upstream symbol present.
REQ-005 SHALL have port sym_ready, output, 1, block accepts a symbol this cycle.
REQ-006 SHALL have port sym, input, 2, encoded 4-state symbol: 00=0, 01=1, 10=x, 11=z.
REQ-007 SHALL have port sym_last, input, 1, marks the final symbol of a frame.
REQ-008 SHALL have port word_valid, output, 1, reassembled word available.
REQ-009 SHALL have port word_ready, input, 1, downstream takes the word.
REQ-010 SHALL have port word_val, output, WORD_BITS, per-bit value (1 only for symbol 1).
REQ-011 SHALL have port word_unk, output, WORD_BITS, per-bit flag for x or z.
REQ-012 SHALL have port word_hiz, output, WORD_BITS, per-bit flag for z only.
REQ-013 SHALL have port unk_cnt, output, $clog2(WORD_BITS+1), count of set bits in word_unk.
REQ-014 SHALL have port len_err, output, 1, frame length differed from WORD_BITS.
REQ-015 SHALL have port frame_cnt, output, 8, count of words delivered; wraps 255->0.

Function
REQ-016 SHALL implement three states: COLLECT, SKIP and HOLD.
REQ-017 SHALL drive sym_ready=1 in COLLECT and SKIP, 0 in HOLD; sym_ready SHALL be registered.
REQ-018 SHALL accept a symbol only on a cycle with sym_valid & sym_ready.
REQ-019 SHALL place symbols MSB-first: the first accepted symbol of a frame goes to bit WORD_BITS-1.
REQ-020 COLLECT, last accepted with fewer than WORD_BITS symbols: SHALL pad the remaining low bits as z (unk=1, hiz=1, val=0), set len_err=1 and go to HOLD.
REQ-021 COLLECT, WORD_BITS-th symbol accepted with sym_last=1: SHALL go to HOLD with len_err=0.
REQ-022 COLLECT, WORD_BITS-th symbol accepted with sym_last=0: SHALL keep the word, set len_err=1 and go to SKIP.
REQ-023 SKIP: SHALL discard accepted symbols and go to HOLD when a symbol with sym_last=1 is accepted.
REQ-024 SHALL assert word_valid in the cycle after the transition into HOLD is decided (one-cycle latency from the last accepted symbol).
REQ-025 HOLD: word_val, word_unk, word_hiz, unk_cnt and len_err SHALL hold stable while word_valid=1 and word_ready=0.
REQ-026 On word_valid & word_ready: SHALL increment frame_cnt, clear word_valid, clear the internal symbol index and return to COLLECT the next cycle. No symbol is accepted in the handshake cycle.
REQ-027 unk_cnt SHALL include padded z bits and SHALL be valid whenever word_valid=1.
REQ-028 Outputs other than frame_cnt are don't-care while word_valid=0; they SHALL NOT change during HOLD.

Reset
REQ-029 While rst_n=0 at a clock edge, SHALL set state=COLLECT, internal index=0, sym_ready=0, word_valid=0, word_val/word_unk/word_hiz=0, unk_cnt=0, len_err=0 and frame_cnt=0.
REQ-030 SHALL set sym_ready=1 on the first edge with rst_n=1.
REQ-031 Reset asserted mid-frame or during HOLD SHALL discard the partial or held word without delivering it.

Verification (WORD_BITS=12)
REQ-032 Send 12 symbols 1,0,1,1,0,0,1,0,1,0,1,1 with last on the 12th -> word_val=0xB2B, word_unk=0, word_hiz=0, unk_cnt=0, len_err=0, frame_cnt=1.
REQ-033 Send 4 symbols 1,x,z,1 with last on the 4th -> word_val=0x900, word_unk=0x6FF, word_hiz=0x2FF, unk_cnt=10, len_err=1.
REQ-034 Send 14 symbols of 0 with last on the 14th -> word_valid rises the cycle after the 14th symbol, word_val=0, len_err=1, and symbols 13-14 are consumed.
REQ-035 Hold word_ready=0 for 5 cycles in HOLD with sym_valid=1 -> sym_ready=0 and outputs stable throughout. Raise word_ready -> the next symbol is accepted the following cycle, not in the handshake cycle.
REQ-036 Accept 6 symbols, pulse rst_n=0 for one cycle, then send a clean 12-symbol frame -> only one word is delivered, it matches the frame, and frame_cnt=1.
REQ-037 Deliver 256 clean frames -> frame_cnt wraps to 0.

Source files
------------

// File: rtl/fourstate_word_rx.sv
// Reassembles a framed stream of 2-bit encoded 4-state symbols into one
// word with value, unknown and high-z planes, MSB-first.
module fourstate_word_rx #(
  parameter int WORD_BITS = 12,
  localparam int CW = $clog2(WORD_BITS + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sym_valid,
  output logic                 sym_ready,
  input  logic [1:0]           sym,
  input  logic                 sym_last,
  output logic                 word_valid,
  input  logic                 word_ready,
  output logic [WORD_BITS-1:0] word_val,
  output logic [WORD_BITS-1:0] word_unk,
  output logic [WORD_BITS-1:0] word_hiz,
  output logic [CW-1:0]        unk_cnt,
  output logic                 len_err,
  output logic [7:0]           frame_cnt
);

  typedef enum logic [1:0] {
    COLLECT,
    SKIP,
    HOLD
  } state_t;

  state_t               state;
  logic [CW-1:0]        idx;
  logic                 acc;
  logic                 full;
  int                   pos;
  logic [WORD_BITS-1:0] nval;
  logic [WORD_BITS-1:0] nunk;
  logic [WORD_BITS-1:0] nhiz;

  function automatic logic [CW-1:0] popc(
    input logic [WORD_BITS-1:0] v
  );
    logic [CW-1:0] c;
    c = '0;
    for (int i = 0; i < WORD_BITS; i++)
      c = c + CW'(v[i]);
    return c;
  endfunction

  assign acc  = sym_valid & sym_ready;
  assign full = (idx == CW'(WORD_BITS - 1));

  // Bits below the current slot become z when the frame ends early.
  always_comb begin
    pos  = WORD_BITS - 1 - int'(idx);
    nval = word_val;
    nunk = word_unk;
    nhiz = word_hiz;
    for (int i = 0; i < WORD_BITS; i++) begin
      if (i == pos) begin
        nval[i] = (sym == 2'b01);
        nunk[i] = sym[1];
        nhiz[i] = (sym == 2'b11);
      end else if (i < pos && sym_last) begin
        nval[i] = 1'b0;
        nunk[i] = 1'b1;
        nhiz[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= COLLECT;
      idx        <= '0;
      sym_ready  <= 1'b0;
      word_valid <= 1'b0;
      word_val   <= '0;
      word_unk   <= '0;
      word_hiz   <= '0;
      unk_cnt    <= '0;
      len_err    <= 1'b0;
      frame_cnt  <= 8'd0;
    end else begin
      unique case (state)
        COLLECT: begin
          sym_ready <= 1'b1;
          if (acc) begin
            word_val <= nval;
            word_unk <= nunk;
            word_hiz <= nhiz;
            unk_cnt  <= popc(nunk);
            if (sym_last) begin
              state      <= HOLD;
              idx        <= '0;
              sym_ready  <= 1'b0;
              word_valid <= 1'b1;
              len_err    <= ~full;
            end else if (full) begin
              state   <= SKIP;
              idx     <= '0;
              len_err <= 1'b1;
            end else begin
              idx <= idx + CW'(1);
            end
          end
        end
        SKIP: begin
          sym_ready <= 1'b1;
          if (acc && sym_last) begin
            state      <= HOLD;
            sym_ready  <= 1'b0;
            word_valid <= 1'b1;
          end
        end
        HOLD: begin
          sym_ready <= 1'b0;
          if (word_ready) begin
            state      <= COLLECT;
            idx        <= '0;
            sym_ready  <= 1'b1;
            word_valid <= 1'b0;
            frame_cnt  <= frame_cnt + 8'd1;
          end
        end
        default: begin
          state     <= COLLECT;
          idx       <= '0;
          sym_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fourstate_word_rx.sv
// Directed bench for fourstate_word_rx at WORD_BITS=12.
module tb_fourstate_word_rx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sym_valid;
  logic        sym_ready;
  logic [1:0]  sym;
  logic        sym_last;
  logic        word_valid;
  logic        word_ready;
  logic [11:0] word_val;
  logic [11:0] word_unk;
  logic [11:0] word_hiz;
  logic [3:0]  unk_cnt;
  logic        len_err;
  logic [7:0]  frame_cnt;

  int tests = 0;
  int fails = 0;

  fourstate_word_rx #(.WORD_BITS(12)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sym_valid  (sym_valid),
    .sym_ready  (sym_ready),
    .sym        (sym),
    .sym_last   (sym_last),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .word_val   (word_val),
    .word_unk   (word_unk),
    .word_hiz   (word_hiz),
    .unk_cnt    (unk_cnt),
    .len_err    (len_err),
    .frame_cnt  (frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present one symbol and wait (bounded) until it is accepted.
  task automatic send(input logic [1:0] s, input logic l);
    int n;
    n = 0;
    sym_valid = 1'b1;
    sym       = s;
    sym_last  = l;
    while (!sym_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!sym_ready) begin
      tests++;
      fails++;
      $error("FAIL sym_timeout observed=0 expected=1");
    end
    @(posedge clk);
    @(negedge clk);
    sym_valid = 1'b0;
    sym_last  = 1'b0;
  endtask

  task automatic send_word(input logic [11:0] v);
    for (int i = 11; i >= 0; i--)
      send({1'b0, v[i]}, i == 0);
  endtask

  task automatic take();
    word_ready = 1'b1;
    @(negedge clk);
    word_ready = 1'b0;
  endtask

  logic [11:0] hv;

  initial begin
    rst_n      = 1'b0;
    sym_valid  = 1'b0;
    sym        = 2'b00;
    sym_last   = 1'b0;
    word_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready", sym_ready, 0);
    chk("rst_wvalid", word_valid, 0);
    chk("rst_val", word_val, 0);
    chk("rst_unk", word_unk, 0);
    chk("rst_cnt", unk_cnt, 0);
    chk("rst_lenerr", len_err, 0);
    chk("rst_frames", frame_cnt, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", sym_ready, 1);

    // clean frame 0xB2B
    send_word(12'hB2B);
    chk("f1_wvalid", word_valid, 1);
    chk("f1_ready_low", sym_ready, 0);
    chk("f1_val", word_val, 12'hB2B);
    chk("f1_unk", word_unk, 0);
    chk("f1_hiz", word_hiz, 0);
    chk("f1_cnt", unk_cnt, 0);
    chk("f1_lenerr", len_err, 0);
    take();
    chk("f1_frames", frame_cnt, 1);
    chk("f1_wvalid_clr", word_valid, 0);

    // short frame 1,x,z,1 padded with z
    send(2'b01, 1'b0);
    send(2'b10, 1'b0);
    send(2'b11, 1'b0);
    send(2'b01, 1'b1);
    chk("f2_wvalid", word_valid, 1);
    chk("f2_val", word_val, 12'h900);
    chk("f2_unk", word_unk, 12'h6FF);
    chk("f2_hiz", word_hiz, 12'h2FF);
    chk("f2_cnt", unk_cnt, 10);
    chk("f2_lenerr", len_err, 1);
    take();
    chk("f2_frames", frame_cnt, 2);

    // long frame of 14 zeros
    for (int i = 0; i < 13; i++) send(2'b00, 1'b0);
    chk("f3_no_early", word_valid, 0);
    send(2'b00, 1'b1);
    chk("f3_wvalid", word_valid, 1);
    chk("f3_val", word_val, 0);
    chk("f3_unk", word_unk, 0);
    chk("f3_lenerr", len_err, 1);

    // stall in HOLD with a symbol waiting
    sym_valid = 1'b1;
    sym       = 2'b01;
    sym_last  = 1'b0;
    hv        = word_val;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_ready", sym_ready, 0);
      chk("hold_wvalid", word_valid, 1);
      chk("hold_val", word_val, hv);
      chk("hold_lenerr", len_err, 1);
    end
    word_ready = 1'b1;
    @(negedge clk);
    word_ready = 1'b0;
    chk("hs_frames", frame_cnt, 3);
    chk("hs_wvalid", word_valid, 0);
    chk("hs_ready", sym_ready, 1);
    @(negedge clk);
    sym_valid = 1'b0;
    for (int i = 10; i >= 0; i--) send(2'b00, i == 0);
    chk("f4_val", word_val, 12'h800);
    chk("f4_lenerr", len_err, 0);
    take();
    chk("f4_frames", frame_cnt, 4);

    // reset mid-frame
    for (int i = 0; i < 6; i++) send(2'b01, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("mid_rst_frames", frame_cnt, 0);
    chk("mid_rst_wvalid", word_valid, 0);
    send_word(12'h5A3);
    chk("f5_wvalid", word_valid, 1);
    chk("f5_val", word_val, 12'h5A3);
    chk("f5_unk", word_unk, 0);
    chk("f5_lenerr", len_err, 0);
    take();
    chk("f5_frames", frame_cnt, 1);
    repeat (3) @(negedge clk);
    chk("f5_single", word_valid, 0);

    // frame counter wrap
    for (int k = 0; k < 254; k++) begin
      send_word(12'(k));
      take();
    end
    chk("frames_255", frame_cnt, 255);
    send_word(12'hFFF);
    chk("f6_val", word_val, 12'hFFF);
    take();
    chk("frames_wrap", frame_cnt, 0);

    // reset while holding a word
    send_word(12'h123);
    chk("f7_wvalid", word_valid, 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("hold_rst_wvalid", word_valid, 0);
    chk("hold_rst_val", word_val, 0);
    @(negedge clk);
    chk("hold_rst_ready", sym_ready, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
